// File: rtl/xover_coeff_ctrl.sv
// rtl/xover_coeff_ctrl.sv - crossover biquad coefficient loader with shadow/active banks
// Byte-framed writes land in the shadow bank; a commit copies it to the active bank on a sample boundary.
module xover_coeff_ctrl #(
   parameter int COEFF_NBITS    = 32,
   parameter int NCOEFF         = 20,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                          i_mck,
   input  logic                          i_rst,
   input  logic [7:0]                    i_byte,
   input  logic                          i_byte_valid,
   output logic                          o_byte_ready,
   input  logic                          i_sample_sync,
   output logic [NCOEFF*COEFF_NBITS-1:0] o_coeffs,
   output logic                          o_commit_pending,
   output logic                          o_commit_done,
   output logic                          o_err
);

   localparam int NBYTES = COEFF_NBITS / 8;
   localparam int AW     = (NCOEFF > 1) ? $clog2(NCOEFF) : 1;
   localparam int BW     = $clog2(NBYTES + 1);
   localparam int GW     = $clog2(TIMEOUT_CYCLES + 1);
   localparam int SW     = COEFF_NBITS - 8;

   typedef enum logic [1:0] {
      S_IDLE        = 2'd0,
      S_ADDR        = 2'd1,
      S_DATA        = 2'd2,
      S_COMMIT_WAIT = 2'd3
   } state_t;

   state_t                 r_state;
   state_t                 w_next;
   logic [COEFF_NBITS-1:0] r_shadow [NCOEFF];
   logic [COEFF_NBITS-1:0] r_active [NCOEFF];
   logic [AW-1:0]          r_addr;
   logic [BW-1:0]          r_bcnt;
   logic [GW-1:0]          r_gap;
   logic [SW-1:0]          r_asm;
   logic                   r_done;
   logic                   r_err;

   logic w_ready;
   logic w_pending;
   logic w_fire;
   logic w_in_frame;
   logic w_timeout;
   logic w_addr_ok;
   logic w_last;
   logic w_commit;
   logic w_bad_addr;

   assign w_fire     = i_byte_valid & w_ready;
   assign w_in_frame = (r_state == S_ADDR) || (r_state == S_DATA);
   assign w_timeout  = w_in_frame && !w_fire && (r_gap == GW'(TIMEOUT_CYCLES - 1));
   assign w_addr_ok  = ({1'b0, i_byte} < 9'(NCOEFF));
   assign w_last     = (r_bcnt == BW'(NBYTES - 1));
   assign w_commit   = (r_state == S_COMMIT_WAIT) && i_sample_sync;
   assign w_bad_addr = (r_state == S_ADDR) && w_fire && !w_addr_ok && (i_byte != 8'hFF);

   always_ff @(posedge i_mck or posedge i_rst) begin
      if (i_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_fire && (i_byte == 8'hA5)) w_next = S_ADDR;
         end
         S_ADDR: begin
            if (w_timeout) begin
               w_next = S_IDLE;
            end else if (w_fire) begin
               if (w_addr_ok)               w_next = S_DATA;
               else if (i_byte == 8'hFF)    w_next = S_COMMIT_WAIT;
               else                         w_next = S_IDLE;
            end
         end
         S_DATA: begin
            if (w_timeout || (w_fire && w_last)) w_next = S_IDLE;
         end
         S_COMMIT_WAIT: begin
            if (i_sample_sync) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Ready drops combinationally with reset so no byte is taken while held in reset.
   always_comb begin
      w_ready   = !i_rst && (r_state != S_COMMIT_WAIT);
      w_pending = (r_state == S_COMMIT_WAIT);
   end

   always_ff @(posedge i_mck or posedge i_rst) begin
      if (i_rst) begin
         r_addr <= '0;
         r_bcnt <= '0;
         r_gap  <= '0;
         r_asm  <= '0;
         r_done <= 1'b0;
         r_err  <= 1'b0;
         for (int k = 0; k < NCOEFF; k++) begin
            r_shadow[k] <= '0;
            r_active[k] <= '0;
         end
      end else begin
         r_done <= w_commit;
         r_err  <= w_bad_addr | w_timeout;

         if (!w_in_frame || w_fire || w_timeout) r_gap <= '0;
         else                                    r_gap <= r_gap + 1'b1;

         if ((r_state == S_ADDR) && w_fire && w_addr_ok) begin
            r_addr <= i_byte[AW-1:0];
            r_bcnt <= '0;
         end

         // The final byte bypasses the assembly register straight into the shadow word.
         if ((r_state == S_DATA) && w_fire) begin
            r_bcnt <= r_bcnt + 1'b1;
            r_asm  <= SW'({r_asm, i_byte});
            if (w_last) r_shadow[r_addr] <= {r_asm, i_byte};
         end

         if (w_commit) begin
            for (int k = 0; k < NCOEFF; k++) r_active[k] <= r_shadow[k];
         end
      end
   end

   genvar g;
   generate
      for (g = 0; g < NCOEFF; g++) begin : g_pack
         assign o_coeffs[g*COEFF_NBITS +: COEFF_NBITS] = r_active[g];
      end
   endgenerate

   assign o_byte_ready     = w_ready;
   assign o_commit_pending = w_pending;
   assign o_commit_done    = r_done;
   assign o_err            = r_err;

endmodule
